// File: rtl/mem_dma_pkg.sv
// -----------------------------------------------------------------------------
// mem_dma_pkg
// Shared constants and types for the memory DMA controller.
//   ADDR_W    : memory word-address width (depth = 2**ADDR_W)
//   DATA_W    : memory word width
//   LEN_W     : copy-length width (legal lengths 0..MEM_DEPTH)
//   MEM_DEPTH : number of memory words
//   dma_state_t : controller FSM states
//   clamp_len : saturates a requested copy length to MEM_DEPTH
// -----------------------------------------------------------------------------
package mem_dma_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 7;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  // A copy can never move more words than the memory holds.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MEM_DEPTH)) begin
      clamp_len = LEN_W'(MEM_DEPTH);
    end else begin
      clamp_len = len;
    end
  endfunction

endpackage

// File: rtl/mem_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// mem_dma_addr_gen
// Address generator for the block-copy engine. Latches the copy command,
// keeps the word offset and the copy direction, and flags the last word.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : command accepted this cycle; latch i_src/i_dst/i_len
//   i_step       : advance the offset by one word in the copy direction
//   i_src, i_dst : source / destination base addresses
//   i_len        : word count (already clamped to MEM_DEPTH)
//   o_src_addr   : src + offset (modulo memory depth)
//   o_dst_addr   : dst + offset (modulo memory depth)
//   o_last       : current offset is the final word of the copy
// -----------------------------------------------------------------------------
module mem_dma_addr_gen
  import mem_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_off;
  logic              r_desc;

  logic              w_desc;
  logic [LEN_W-1:0]  w_len_m1;

  // Copying toward higher addresses walks backwards so an overlapping
  // source is never overwritten before it is read.
  assign w_desc   = (i_dst > i_src);
  assign w_len_m1 = i_len - LEN_W'(1'b1);

  // Command latch and offset counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= {ADDR_W{1'b0}};
      r_dst  <= {ADDR_W{1'b0}};
      r_len  <= {LEN_W{1'b0}};
      r_off  <= {ADDR_W{1'b0}};
      r_desc <= 1'b0;
    end else if (i_load) begin
      r_src  <= i_src;
      r_dst  <= i_dst;
      r_len  <= i_len;
      r_desc <= w_desc;
      r_off  <= w_desc ? w_len_m1[ADDR_W-1:0] : {ADDR_W{1'b0}};
    end else if (i_step) begin
      r_off  <= r_desc ? (r_off - ADDR_W'(1'b1)) : (r_off + ADDR_W'(1'b1));
    end else begin
      r_off  <= r_off;
    end
  end

  assign o_src_addr = r_src + r_off;
  assign o_dst_addr = r_dst + r_off;

  // Descending copies end at offset 0, ascending ones at len-1.
  assign o_last = r_desc ? (r_off == {ADDR_W{1'b0}})
                         : (LEN_W'(r_off) == (r_len - LEN_W'(1'b1)));

endmodule

// File: rtl/mem_dma_ctrl.sv
// -----------------------------------------------------------------------------
// mem_dma_ctrl
// Initiator-side controller for a 64 x 16 data memory. Arbitrates single-word
// CPU loads/stores against a block-copy engine (memmove semantics). The CPU
// always wins in IDLE; a pending copy command waits for the next free cycle.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cpu_req_valid/ready/we/addr/wdata : CPU request handshake
//   cpu_rsp_valid, cpu_rsp_rdata    : load response (1-cycle pulse, data held)
//   dma_valid/ready/src/dst/len     : copy command handshake
//   dma_busy, dma_done              : copy status
//   mem_addr, mem_data_in, mem_write_en : drive the memory
//   mem_data_out                    : combinational memory read data
// -----------------------------------------------------------------------------
module mem_dma_ctrl
  import mem_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  dma_state_t        r_state;
  dma_state_t        w_next_state;
  logic [DATA_W-1:0] r_buf;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_dma_done;
  logic              r_dma_busy;

  logic              w_cpu_acc;
  logic              w_dma_acc;
  logic              w_step;
  logic [LEN_W-1:0]  w_len_eff;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic              w_last;

  assign w_len_eff = clamp_len(dma_len);

  mem_dma_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dma_acc),
    .i_step     (w_step),
    .i_src      (dma_src),
    .i_dst      (dma_dst),
    .i_len      (w_len_eff),
    .o_src_addr (w_src_addr),
    .o_dst_addr (w_dst_addr),
    .o_last     (w_last)
  );

  // Next-state, arbitration and memory-port muxing.
  always_comb begin
    w_next_state  = r_state;
    cpu_req_ready = 1'b0;
    dma_ready     = 1'b0;
    mem_addr      = cpu_req_addr;
    mem_data_in   = cpu_req_wdata;
    mem_write_en  = 1'b0;
    w_cpu_acc     = 1'b0;
    w_dma_acc     = 1'b0;
    w_step        = 1'b0;

    case (r_state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        dma_ready     = ~cpu_req_valid;
        mem_write_en  = cpu_req_valid & cpu_req_we;
        w_cpu_acc     = cpu_req_valid;
        w_dma_acc     = dma_valid & ~cpu_req_valid;
        if (w_dma_acc) begin
          if (w_len_eff == {LEN_W{1'b0}}) begin
            w_next_state = DONE;
          end else begin
            w_next_state = RD;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RD: begin
        mem_addr     = w_src_addr;
        w_next_state = WR;
      end
      WR: begin
        mem_addr     = w_dst_addr;
        mem_data_in  = r_buf;
        mem_write_en = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_step       = 1'b1;
          w_next_state = RD;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    // Reset blocks every handshake and write in the same cycle it is seen.
    if (rst) begin
      cpu_req_ready = 1'b0;
      dma_ready     = 1'b0;
      mem_write_en  = 1'b0;
      w_cpu_acc     = 1'b0;
      w_dma_acc     = 1'b0;
      w_step        = 1'b0;
      w_next_state  = IDLE;
    end else begin
      w_next_state  = w_next_state;
    end
  end

  // State register, copy buffer and registered status/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_dma_done  <= 1'b0;
      r_dma_busy  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Status bits track the state being entered so they line up with it.
      r_dma_busy  <= (w_next_state != IDLE);
      r_dma_done  <= (w_next_state == DONE);
      r_rsp_valid <= w_cpu_acc & ~cpu_req_we;
      if (w_cpu_acc && !cpu_req_we) begin
        r_rsp_rdata <= mem_data_out;
      end else begin
        r_rsp_rdata <= r_rsp_rdata;
      end
      if (r_state == RD) begin
        r_buf <= mem_data_out;
      end else begin
        r_buf <= r_buf;
      end
    end
  end

  assign cpu_rsp_valid = r_rsp_valid;
  assign cpu_rsp_rdata = r_rsp_rdata;
  assign dma_done      = r_dma_done;
  assign dma_busy      = r_dma_busy;

endmodule
